mult_seq_ctrl: RTL and testbench
================================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL expose clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL expose rst_i, input, 1, asynchronous, active-high reset.
REQ-003 SHALL expose start_i, input, 1, the EX-stage instruction is mult (ALU control code 4'b0011).
REQ-004 SHALL expose flush_i, input, 1, pipeline flush; abort any operation in progress.
REQ-005 SHALL expose src1_i, input, 32, multiplicand; sampled only on accept.
REQ-006 SHALL expose src2_i, input, 32, multiplier; sampled only on accept.
REQ-007 SHALL expose stall_o, output, 1, freeze PC/IF/ID/EX while the multiply is in flight.
REQ-008 SHALL expose busy_o, output, 1, high in RUN.
REQ-009 SHALL expose done_o, output, 1, one-cycle pulse, result_o valid.
REQ-010 SHALL expose result_o, output, 32, low 32 bits of src1*src2; registered; held until the next done_o.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE.
REQ-012 Accept SHALL occur when state==IDLE, start_i=1 and flush_i=0; on accept: acc<=0, mcand<=src1_i, mplr<=src2_i, count<=0, next state RUN.
REQ-013 Each RUN cycle SHALL do: if mplr[0] then acc<=acc+mcand (mod 2^32); mcand<=mcand<<1; mplr<=mplr>>1; count<=count+1.
REQ-014 RUN SHALL go to DONE when count==31 or (mplr>>1)==0 in the current cycle; otherwise it stays in RUN.
REQ-015 RUN cycles SHALL therefore equal max(1, bit index of the MSB set in src2 + 1); the maximum is 32.
REQ-016 On entry to DONE, result_o SHALL hold the final acc value.
REQ-017 In DONE: done_o=1 and stall_o=0, so the mult advances that cycle.
REQ-018 The next state after DONE SHALL be IDLE unconditionally; start_i in DONE is ignored (it is the same instruction).
REQ-019 stall_o SHALL be combinational: (IDLE && start_i && !flush_i) || RUN.
REQ-020 busy_o SHALL be high only in RUN; done_o SHALL be high only in DONE.
REQ-021 flush_i SHALL have priority over all other inputs: from any state, next state IDLE, no done_o, and result_o unchanged.
REQ-022 Back-to-back mult SHALL be accepted from IDLE on the cycle after DONE, with no lost or duplicated operation.
REQ-023 Result SHALL be identical for signed and unsigned operands (low word only); no overflow flag.

Reset
REQ-024 On rst_i=1, asynchronously: state=IDLE, acc=0, mcand=0, mplr=0, count=0, result_o=0, done_o=0, busy_o=0.
REQ-025 During reset, stall_o SHALL be 0 regardless of start_i.
REQ-026 Reset asserted mid-RUN SHALL discard the operation; after release, the unit SHALL accept a new start normally.

Structure
REQ-027 The shared package SHALL hold: ALU control code MULT=4'b0011, MULT_W=32, COUNT_W=5, and the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
REQ-028 The controller (FSM, counter, stall/done) SHALL be separated from one sub-module, mult_shift_add_dp (acc/mcand/mplr registers, adder, shifters, mplr-zero detect).
REQ-029 The illegal state encoding 2'd3 SHALL return to IDLE.

Verification
REQ-030 Scenario: src1=3, src2=5, start_i held -> 3 RUN cycles, then DONE with result_o=15, stall_o low in the DONE cycle only.
REQ-031 Scenario: src1=0xFFFFFFFF, src2=2 -> 2 RUN cycles, result_o=0xFFFFFFFE.
REQ-032 Scenario: src1=1, src2=0x80000000 -> 32 RUN cycles, result_o=0x80000000; src2=0 -> 1 RUN cycle, result_o=0.
REQ-033 Scenario: flush_i pulsed in the 5th RUN cycle -> IDLE the next cycle, no done_o, result_o keeps its prior value, stall_o drops.
REQ-034 Scenario: rst_i asserted mid-RUN -> all outputs 0 immediately; the next mult 7*6 yields 42.
REQ-035 Scenario: two consecutive mults 2*3 then 4*4 -> two done_o pulses, result_o 6 then 16, one IDLE cycle between them.

Source files
------------

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared constants for the sequential shift-add multiplier.
//   MULT    : ALU control code of the mult instruction
//   MULT_W  : operand / result width
//   COUNT_W : width of the RUN-cycle counter (up to 32 cycles)
//   IDLE/RUN/DONE : controller state encoding (2'd3 is illegal)
package mult_seq_ctrl_pkg;

  localparam logic [3:0] MULT    = 4'b0011;
  localparam int         MULT_W  = 32;
  localparam int         COUNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier.
//   clk_i, rst_i : clock, async active-high reset
//   load         : capture operands and clear the accumulator
//   step         : perform one shift-add iteration
//   src1, src2   : multiplicand / multiplier (sampled on load only)
//   acc_next     : accumulator value after the current iteration
//   mplr_last    : multiplier has no set bits above bit 0 (last iteration)
module mult_shift_add_dp
  import mult_seq_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              step,
  input  logic [MULT_W-1:0] src1,
  input  logic [MULT_W-1:0] src2,
  output logic [MULT_W-1:0] acc_next,
  output logic              mplr_last
);

  logic [MULT_W-1:0] acc;
  logic [MULT_W-1:0] mcand;
  logic [MULT_W-1:0] mplr;

  // Adder wraps mod 2^32, which gives the same low word for signed and
  // unsigned operands.
  assign acc_next  = mplr[0] ? acc + mcand : acc;
  assign mplr_last = (mplr[MULT_W-1:1] == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= src1;
      mplr  <= src2;
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle multiply controller for the EX stage.
//   clk_i, rst_i : clock, async active-high reset
//   start_i      : EX-stage instruction is mult
//   flush_i      : pipeline flush, aborts any operation in progress
//   src1_i/src2_i: operands, sampled on accept
//   stall_o      : freeze PC/IF/ID/EX while the multiply is in flight
//   busy_o       : high in RUN
//   done_o       : one-cycle pulse, result_o valid
//   result_o     : low 32 bits of src1*src2, held until the next done_o
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [MULT_W-1:0] src1_i,
  input  logic [MULT_W-1:0] src2_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [MULT_W-1:0] result_o
);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [COUNT_W-1:0] count;
  logic [MULT_W-1:0]  acc_next;
  logic               mplr_last;
  logic               accept;
  logic               step;
  logic               finish;

  assign accept = (state == IDLE) && start_i && !flush_i;
  assign step   = (state == RUN) && !flush_i;
  // Leave RUN after the iteration that consumes the top set multiplier bit,
  // or after the 32nd iteration at the latest.
  assign finish = step && ((count == COUNT_W'(MULT_W - 1)) || mplr_last);

  mult_shift_add_dp u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (accept),
    .step      (step),
    .src1      (src1_i),
    .src2      (src2_i),
    .acc_next  (acc_next),
    .mplr_last (mplr_last)
  );

  // NOTE: state_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_next = RUN;
        RUN:     if (finish)  state_next = DONE;
        DONE:    state_next = IDLE;  // start_i here is the same instruction
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= '0;
      result_o <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= '0;
      end else if (step) begin
        count <= count + 1'b1;
      end
      // Capture the final sum on the edge that enters DONE.
      if (finish) begin
        result_o <= acc_next;
      end
    end
  end

  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);
  // Reset forces stall low even though the accept term could see start_i.
  assign stall_o = !rst_i && (accept || (state == RUN));

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus random
// operands checked against an arithmetic reference model.
module tb_mult_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_result;

  mult_seq_ctrl dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: number of RUN cycles is the position of the highest set
  // multiplier bit, at least one.
  function automatic int ref_cycles(input logic [31:0] b);
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Entry: 2 time units after a rising edge, DUT in IDLE.
  // Exit: same phase, DUT in IDLE after the DONE cycle.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit chain);
    int runs;
    bit got_done;
    check("idle_busy", busy_o, 0);
    check("idle_done", done_o, 0);
    check("idle_result_held", result_o, last_result);
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    flush_i = 1'b0;
    #1;
    check("accept_stall", stall_o, 1);
    runs     = 0;
    got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      // Operands must have been captured on accept; scramble them.
      src1_i = $urandom;
      src2_i = $urandom;
      #1;
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
      runs++;
      check("run_busy", busy_o, 1);
      check("run_stall", stall_o, 1);
    end
    check("done_seen", got_done, 1);
    check("run_cycles", runs, ref_cycles(b));
    check("done_stall", stall_o, 0);
    check("done_busy", busy_o, 0);
    check("result", result_o, ref_product(a, b));
    last_result = ref_product(a, b);
    if (!chain) start_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b1;
    flush_i     = 1'b0;
    src1_i      = '0;
    src2_i      = '0;
    last_result = '0;
    #3;
    check("rst_stall", stall_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    start_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    run_mult(32'd3, 32'd5, 1'b0);
    run_mult(32'hFFFF_FFFF, 32'd2, 1'b0);
    run_mult(32'd1, 32'h8000_0000, 1'b0);
    run_mult(32'h1234_5678, 32'd0, 1'b0);

    // Back-to-back: start held through DONE, one IDLE cycle between.
    run_mult(32'd2, 32'd3, 1'b1);
    run_mult(32'd4, 32'd4, 1'b0);

    // Flush in the 5th RUN cycle.
    src1_i  = 32'd5;
    src2_i  = 32'hFF;
    start_i = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("flush_pre_busy", busy_o, 1);
    end
    tick();
    flush_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("flush_cycle_busy", busy_o, 1);
    tick();
    check("flush_after_busy", busy_o, 0);
    check("flush_after_done", done_o, 0);
    check("flush_after_stall", stall_o, 0);
    check("flush_result_kept", result_o, last_result);
    flush_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("flush_no_done", done_o, 0);
    end

    // Reset mid-RUN discards the operation.
    src1_i  = 32'd9;
    src2_i  = 32'hFFFF;
    start_i = 1'b1;
    #1;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    check("midrst_stall", stall_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_result", result_o, 0);
    last_result = '0;
    tick();
    rst_i   = 1'b0;
    start_i = 1'b0;
    tick();
    run_mult(32'd7, 32'd6, 1'b0);

    // Random operands, multiplier width varied so RUN lengths spread out.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_mult(a, b, bit'($urandom_range(0, 1)));
    end
    start_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
